// File: rtl/aes_inv_rounddata_serial.sv
// Word-serial AES inverse round datapath: one 32-bit column per cycle through
// a single inverse S-box word and a single InvMixColumn word.
module aes_inv_rounddata_serial (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   round_kind,
    input  logic [127:0] round_key,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [127:0] acc_q, acc_d;
    logic [127:0] dout_q, dout_d;
    logic         mix_q, mix_d;

    logic [127:0] isr_s;
    logic [31:0]  word_w;
    logic [31:0]  key_w;
    logic [31:0]  sub_w;
    logic [31:0]  t_w;
    logic [31:0]  res_w;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] p;
        sq = gmul(a, a);
        p  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gmul(sq, sq);
            p  = gmul(p, sq);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        o0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        o1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        o2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        o3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        return {o0, o1, o2, o3};
    endfunction

    // InvShiftRows is pure wiring: out(r,c) = in(r,(c-r) mod 4)
    always_comb begin
        isr_s = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr_s[127-32*c-8*r -: 8] = st_q[127-32*((c-r+4)%4)-8*r -: 8];
            end
        end
    end

    always_comb begin
        word_w = isr_s[31:0];
        key_w  = key_q[31:0];
        case (cnt_q)
            2'd0: begin
                word_w = isr_s[31:0];
                key_w  = key_q[31:0];
            end
            2'd1: begin
                word_w = isr_s[63:32];
                key_w  = key_q[63:32];
            end
            2'd2: begin
                word_w = isr_s[95:64];
                key_w  = key_q[95:64];
            end
            default: begin
                word_w = isr_s[127:96];
                key_w  = key_q[127:96];
            end
        endcase
    end

    always_comb begin
        sub_w = {inv_sbox(word_w[31:24]), inv_sbox(word_w[23:16]),
                 inv_sbox(word_w[15:8]),  inv_sbox(word_w[7:0])};
        t_w   = sub_w ^ key_w;
        res_w = mix_q ? inv_mix_col(t_w) : t_w;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        key_d   = key_q;
        mix_d   = mix_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d  = data_in;
                    key_d = round_key;
                    mix_d = (round_kind != 2'b10);
                    if (round_kind == 2'b00) begin
                        dout_d  = data_in ^ round_key;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = {res_w, acc_q[127:32]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    dout_d  = {res_w, acc_q[127:32]};
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            st_q    <= '0;
            key_q   <= '0;
            mix_q   <= 1'b0;
            acc_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            key_q   <= key_d;
            mix_q   <= mix_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign data_out  = dout_q;

endmodule

// File: tb/tb_aes_inv_rounddata_serial.sv
// Bench for aes_inv_rounddata_serial: cycle model plus round-trip recovery
// through a forward AES model built from first principles.
module tb_aes_inv_rounddata_serial;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   round_kind = 2'b00;
    logic [127:0] round_key = '0;
    logic [127:0] data_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] data_out;

    int total = 0;
    int bad = 0;
    logic run_chk = 1'b0;

    logic [7:0] sb [256];
    logic [7:0] isb [256];

    aes_inv_rounddata_serial dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .round_kind(round_kind),
        .round_key(round_key),
        .data_in(data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] sr(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
        return o;
    endfunction

    function automatic logic [127:0] isr(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = s[127-32*((c-r+4)%4)-8*r -: 8];
        return o;
    endfunction

    function automatic logic [127:0] subb(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sb[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] isubb(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = isb[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mc(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = gm(a[r], 8'h02) ^ gm(a[(r+1)%4], 8'h03)
                                      ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    // MixColumns has order 4, so three applications give its inverse
    function automatic logic [127:0] imc(input logic [127:0] s);
        return mc(mc(mc(s)));
    endfunction

    function automatic logic [127:0] ref_inv(input logic [1:0] kind,
                                             input logic [127:0] s,
                                             input logic [127:0] k);
        logic [127:0] t;
        if (kind == 2'b00) return s ^ k;
        t = isubb(isr(s)) ^ k;
        return (kind == 2'b10) ? t : imc(t);
    endfunction

    function automatic logic [127:0] fwd(input logic [1:0] kind,
                                         input logic [127:0] s,
                                         input logic [127:0] k);
        if (kind == 2'b00) return s ^ k;
        if (kind == 2'b10) return sr(subb(s ^ k));
        return sr(subb(mc(s) ^ k));
    endfunction

    logic         m_idle = 1'b1;
    logic         m_hold = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_out = '0;
    logic [127:0] m_pend = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_idle = 1'b1;
            m_hold = 1'b0;
            m_cnt  = 0;
            m_out  = '0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 1'b0;
                if (round_kind == 2'b00) begin
                    m_out  = ref_inv(round_kind, data_in, round_key);
                    m_hold = 1'b1;
                end else begin
                    m_pend = ref_inv(round_kind, data_in, round_key);
                    m_cnt  = 4;
                end
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_out  = m_pend;
                m_hold = 1'b1;
            end
        end else if (m_hold && out_ready) begin
            m_hold = 1'b0;
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (run_chk && !reset) begin
            chk("in_ready", {127'd0, in_ready}, {127'd0, m_idle});
            chk("out_valid", {127'd0, out_valid}, {127'd0, m_hold});
            chk("data_out", data_out, m_out);
        end
    end

    task automatic do_txn(input logic [1:0] kind, input logic [127:0] d,
                          input logic [127:0] k, input int hold,
                          output logic [127:0] res);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("wait_in_ready", 0, 1);
        round_kind = kind;
        data_in    = d;
        round_key  = k;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (out_valid || n >= 20) break;
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            data_in   = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", 128'(n), (kind == 2'b00) ? 128'd1 : 128'd5);
        res = data_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            in_valid   = 1'($urandom);
            data_in    = {$urandom, $urandom, $urandom, $urandom};
            round_kind = 2'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] res, res2, s, k, x, v;
        logic [1:0] kind;
        int found;

        for (int a = 0; a < 256; a++) begin
            logic [7:0] b, a8;
            a8 = 8'(a);
            b = 8'h00;
            found = 0;
            for (int j = 1; j < 256; j++)
                if (found == 0 && gm(a8, 8'(j)) == 8'h01) begin
                    b = 8'(j);
                    found = 1;
                end
            sb[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                    ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);

        chk("pin_sbox53", {120'd0, sb[8'h53]}, {120'd0, 8'hed});
        chk("pin_isbox00", {120'd0, isb[8'h00]}, {120'd0, 8'h52});
        chk("pin_model_init",
            ref_inv(2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h13111d7fe3944a17f307a78b4d2b30c5),
            128'h7ad5fda789ef4e272bca100b3d9ff59f);
        chk("pin_model_final",
            ref_inv(2'b10, 128'h7ad5fda789ef4e272bca100b3d9ff59f,
                    128'h549932d1f08557681093ed9cbe2c974e),
            128'he9f74eec023020f61bf2ccf2353c21c7);
        v = imc({96'd0, 32'h8e4da1bc});
        chk("pin_model_imc", {96'd0, v[31:0]}, {96'd0, 32'hdb135345});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_data_out", data_out, 128'd0);
        reset = 1'b0;
        run_chk = 1'b1;

        do_txn(2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               128'h13111d7fe3944a17f307a78b4d2b30c5, 0, res);
        chk("c1_initial", res, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
        do_txn(2'b10, 128'h7ad5fda789ef4e272bca100b3d9ff59f,
               128'h549932d1f08557681093ed9cbe2c974e, 1, res);
        chk("c1_final", res, 128'he9f74eec023020f61bf2ccf2353c21c7);
        do_txn(2'b01, 128'h7ad5fda789ef4e272bca100b3d9ff59f,
               128'h549932d1f08557681093ed9cbe2c974e, 0, res);
        chk("c1_middle", res, imc(128'he9f74eec023020f61bf2ccf2353c21c7));
        do_txn(2'b01, 128'd0, {96'd0, 32'h8e4da1bc ^ 32'h52525252}, 0, res);
        chk("column3", {96'd0, res[31:0]}, {96'd0, 32'hdb135345});

        do_txn(2'b10, 128'h0123456789abcdeffedcba9876543210,
               128'h00112233445566778899aabbccddeeff, 10, res);
        chk("backpressure",
            res, ref_inv(2'b10, 128'h0123456789abcdeffedcba9876543210,
                         128'h00112233445566778899aabbccddeeff));

        round_kind = 2'b01;
        data_in    = 128'hffeeddccbbaa99887766554433221100;
        round_key  = 128'h0f0e0d0c0b0a09080706050403020100;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrun_rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("midrun_rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrun_rst_data_out", data_out, 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        s = 128'h3243f6a8885a308d313198a2e0370734;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        do_txn(2'b01, fwd(2'b01, s, k), k, 0, res);
        chk("after_rst_roundtrip", res, s);

        for (int i = 0; i < 1000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            kind = 2'($urandom_range(0, 3));
            x = fwd(kind, s, k);
            do_txn(kind, x, k, $urandom_range(0, 3), res);
            chk("roundtrip", res, s);
            if (i % 40 == 0) begin
                do_txn(2'b01, x, k, 0, res);
                do_txn(2'b11, x, k, 0, res2);
                chk("kind11_eq_01", res2, res);
            end
        end

        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
